// File: rtl/tail_lamp_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : tail_lamp_if
// Brief    : Request inputs and lamp/mode outputs of the tail lamp sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tail_lamp_if #(
    parameter int LAMPS = 3
);
    logic             turn_left;
    logic             turn_right;
    logic             emergency;
    logic             brake;
    logic [LAMPS-1:0] left_lamp;
    logic [LAMPS-1:0] right_lamp;
    logic [1:0]       mode;

    modport master (
        output turn_left, turn_right, emergency, brake,
        input  left_lamp, right_lamp, mode
    );

    modport slave (
        input  turn_left, turn_right, emergency, brake,
        output left_lamp, right_lamp, mode
    );
endinterface

`default_nettype wire

// File: rtl/tail_lamp_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tail_lamp_sequencer
// Brief    : Sequential turn / hazard tail lamp driver with brake override.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tail_lamp_sequencer #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    tail_lamp_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_HAZARD = 2'b11
    } mode_t;

    localparam int STEP_W = 4;
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [STEP_W-1:0] TURN_LAST = STEP_W'(LAMPS);
    localparam logic [STEP_W-1:0] HAZ_LAST  = STEP_W'(2 * LAMPS - 1);
    localparam logic [STEP_W-1:0] HAZ_SPAN  = STEP_W'(2 * LAMPS);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);

    mode_t             req_mode;
    mode_t             mode_q;
    logic              brake_q;
    logic [STEP_W-1:0] step;
    logic [PRE_W-1:0]  prescale;
    logic [STEP_W-1:0] step_last;
    logic [STEP_W-1:0] lit;
    logic [LAMPS-1:0]  pattern;
    logic [LAMPS-1:0]  brake_mask;
    logic [LAMPS-1:0]  left_d;
    logic [LAMPS-1:0]  right_d;

    // Both turn requests at once is treated as no request.
    always_comb begin
        req_mode = MODE_IDLE;
        if (bus.emergency) begin
            req_mode = MODE_HAZARD;
        end else if (bus.turn_left ^ bus.turn_right) begin
            req_mode = bus.turn_left ? MODE_LEFT : MODE_RIGHT;
        end
    end

    assign step_last = (mode_q == MODE_HAZARD) ? HAZ_LAST : TURN_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= MODE_IDLE;
            brake_q  <= 1'b0;
            step     <= '0;
            prescale <= '0;
        end else begin
            mode_q  <= req_mode;
            brake_q <= bus.brake;
            if ((req_mode != mode_q) || (mode_q == MODE_IDLE)) begin
                step     <= '0;
                prescale <= '0;
            end else if (prescale == PRE_LAST) begin
                prescale <= '0;
                step     <= (step == step_last) ? '0 : step + STEP_W'(1);
            end else begin
                prescale <= prescale + PRE_W'(1);
            end
        end
    end

    // Hazard runs up then back down; the falling half mirrors around LAMPS.
    always_comb begin
        lit = step;
        if ((mode_q == MODE_HAZARD) && (step > TURN_LAST)) begin
            lit = HAZ_SPAN - step;
        end
        pattern = '0;
        for (int i = 0; i < LAMPS; i++) begin
            pattern[i] = (STEP_W'(i) < lit);
        end
    end

    assign brake_mask = {LAMPS{brake_q}};

    always_comb begin
        left_d  = '0;
        right_d = '0;
        case (mode_q)
            MODE_LEFT: begin
                left_d  = pattern;
                right_d = brake_mask;
            end
            MODE_RIGHT: begin
                left_d  = brake_mask;
                right_d = pattern;
            end
            MODE_HAZARD: begin
                left_d  = pattern;
                right_d = pattern;
            end
            default: begin
                left_d  = brake_mask;
                right_d = brake_mask;
            end
        endcase
    end

    assign bus.left_lamp  = left_d;
    assign bus.right_lamp = right_d;
    assign bus.mode       = mode_q;

endmodule

`default_nettype wire

// File: doc/tail_lamp_sequencer.md
TAIL_LAMP_SEQUENCER -- requirements
Module: tail_lamp_sequencer

Interface
REQ-001 Parameter LAMPS, default 3, lamps per side; legal range 1..8.
REQ-002 Parameter TICK_DIV, default 4, clock cycles per sequence step; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 turn_left  input  1  left turn request, level-sensitive.
REQ-006 turn_right  input  1  right turn request, level-sensitive.
REQ-007 emergency  input  1  hazard request, level-sensitive.
REQ-008 brake  input  1  brake pedal, level-sensitive.
REQ-009 left_lamp  output  LAMPS  left lamp drive; bit 0 is innermost.
REQ-010 right_lamp  output  LAMPS  right lamp drive; bit 0 is innermost.
REQ-011 mode  output  2  active mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.

Function
REQ-012 Requested mode SHALL be decoded with this priority: emergency -> HAZARD; else exactly one of turn_left/turn_right -> LEFT/RIGHT; else (none, or both) -> IDLE.
REQ-013 mode_q, brake_q, step counter and prescaler SHALL be registers updated every rising clk edge while rst is high.
REQ-014 mode_q SHALL load the requested mode each edge; if it differs from the current mode_q, step and prescaler SHALL both load 0 on that edge.
REQ-015 Otherwise the prescaler SHALL count 0..TICK_DIV-1 and wrap; step SHALL advance only on the edge where prescaler == TICK_DIV-1.
REQ-016 LEFT/RIGHT step range SHALL be 0..LAMPS, wrapping LAMPS -> 0; period is (LAMPS+1)*TICK_DIV cycles.
REQ-017 HAZARD step range SHALL be 0..2*LAMPS-1, wrapping to 0; period is 2*LAMPS*TICK_DIV cycles.
REQ-018 In IDLE, step and prescaler SHALL be held at 0.
REQ-019 Turn pattern at step k SHALL be thermometer code with the k lowest bits set: k=0 all off, k=LAMPS all on.
REQ-020 Hazard pattern at step k SHALL light k lowest bits for k <= LAMPS and 2*LAMPS-k lowest bits for k > LAMPS; it SHALL be driven identically on both sides.
REQ-021 In LEFT, left_lamp SHALL show the turn pattern; right_lamp SHALL be all ones when brake_q=1, else 0. RIGHT SHALL behave symmetrically.
REQ-022 In IDLE, both outputs SHALL be all ones when brake_q=1, else 0.
REQ-023 In HAZARD, brake_q SHALL have no effect on either output.
REQ-024 Outputs and mode SHALL be pure decodes of mode_q, step and brake_q; latency from input change to output change SHALL be exactly one clock edge.
REQ-025 A mode change mid-sequence SHALL restart the new sequence at step 0 with no residual pattern from the old mode.
REQ-026 A brake change SHALL NOT disturb step or prescaler.

Reset
REQ-027 While rst=0, mode_q SHALL be IDLE and step, prescaler and brake_q SHALL be 0, forced asynchronously; left_lamp, right_lamp and mode SHALL read 0.
REQ-028 The first rising edge with rst=1 SHALL sample inputs normally.
REQ-029 Asserting rst mid-sequence SHALL clear all outputs immediately, without waiting for a clock edge.

Verification (LAMPS=3, TICK_DIV=4)
REQ-030 turn_left=1 held -> mode=01; left_lamp holds each value for 4 cycles in order 000,001,011,111,000; right_lamp=000 throughout.
REQ-031 emergency=1 held -> both sides hold each value for 4 cycles in order 000,001,011,111,011,001,000 (24-cycle period); mode=11.
REQ-032 turn_right=1 with brake=1 -> right_lamp sequences; left_lamp=111; dropping brake mid-step -> left_lamp=000 next edge and right step timing unchanged.
REQ-033 turn_left=1 and turn_right=1 together, brake=0 -> mode=00, both lamps 000; raising emergency -> HAZARD starts at step 0.
REQ-034 LEFT running at left_lamp=011, switch to turn_right -> next edge mode=10, both sides 000, right_lamp first reaches 001 exactly 4 cycles later.
REQ-035 Mid-hazard, drive rst=0 between clock edges -> outputs 000/000 and mode=00 immediately; release -> IDLE until inputs request otherwise; repeat with TICK_DIV=1 and LAMPS=1.
